// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the PISO serializer.
// PISO_PARITY_EN adds one trailing even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 32'sd1;
`else
    return width;
`endif
  endfunction

  function automatic int count_width(input int width);
    return $clog2(frame_len(width) + 32'sd1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear/enable controlled, flags the final bit position.
module piso_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CW        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_r;

  // Count wraps to zero after the final bit so it never reaches FRAME_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= last ? '0 : count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and ser_en stall.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = count_width(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shreg_r;
  logic             handshake_s;
  logic             last_s;
  logic             data_bit_s;
  logic             cnt_en_s;

  assign handshake_s = load_valid && load_ready;
  assign data_bit_s  = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
  assign cnt_en_s    = (state_r == SHIFT) && ser_en;

  piso_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (handshake_s),
    .enable (cnt_en_s),
    .last   (last_s)
  );

`ifdef PISO_PARITY_EN
  logic parity_r;

  // Parity of the captured word, presented after the last data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (handshake_s) begin
      parity_r <= ^load_data;
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register: a new word on handshake overrides the shift of the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= '0;
    end else if (handshake_s) begin
      shreg_r <= load_data;
    end else if (cnt_en_s) begin
      shreg_r <= MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0} : {1'b0, shreg_r[WIDTH-1:1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s    = state_r;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        busy       = 1'b1;
        ser_last   = last_s;
        load_ready = last_s && ser_en;
`ifdef PISO_PARITY_EN
        ser_bit    = last_s ? parity_r : data_bit_s;
`else
        ser_bit    = data_bit_s;
`endif
        if (ser_en && last_s) begin
          state_s = load_valid ? SHIFT : IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB-first and LSB-first instances).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0, lv2 = 1'b0;
  logic [7:0] ld  = 8'h00, ld2 = 8'h00;
  logic       se  = 1'b1, se2 = 1'b1;
  logic       lr, sb, sv, sl, bz;
  logic       lr2, sb2, sv2, sl2, bz2;

  exp_t q_m[$];
  exp_t q_l[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr), .load_data(ld),
    .ser_en(se), .ser_bit(sb), .ser_valid(sv), .ser_last(sl), .busy(bz)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2), .load_data(ld2),
    .ser_en(se2), .ser_bit(sb2), .ser_valid(sv2), .ser_last(sl2), .busy(bz2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected serial stream for one word.
  task automatic push_word(input logic [7:0] w, input bit msb, input bit to_lsb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = msb ? w[7-i] : w[i];
      e.l = (i == FL - 1);
      if (to_lsb) q_l.push_back(e); else q_m.push_back(e);
    end
    if (FL == 9) begin
      e.b = ^w;
      e.l = 1'b1;
      if (to_lsb) q_l.push_back(e); else q_m.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sv) begin
      tests++;
      if (q_m.size() == 0) begin
        failed++;
        $display("FAIL sb_msb_empty: ser_valid=1 with no expected bit at %0t", $time);
      end else begin
        if ({sb, sl} !== {q_m[0].b, q_m[0].l}) begin
          failed++;
          $display("FAIL sb_msb: bit/last=%b%b expected %b%b at %0t", sb, sl, q_m[0].b, q_m[0].l, $time);
        end
        if (se) void'(q_m.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sv2) begin
      tests++;
      if (q_l.size() == 0) begin
        failed++;
        $display("FAIL sb_lsb_empty: ser_valid=1 with no expected bit at %0t", $time);
      end else begin
        if ({sb2, sl2} !== {q_l[0].b, q_l[0].l}) begin
          failed++;
          $display("FAIL sb_lsb: bit/last=%b%b expected %b%b at %0t", sb2, sl2, q_l[0].b, q_l[0].l, $time);
        end
        if (se2) void'(q_l.pop_front());
      end
    end
  end

  task automatic test_reset();
    #1;
    tests++;
    if ({sv, sb, sl, bz} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_outputs: valid/bit/last/busy=%b expected 0000", {sv, sb, sl, bz});
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (lr !== 1'b1 || lr2 !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: load_ready=%b/%b expected 1/1", lr, lr2);
    end
  endtask

  task automatic test_msb_a5();
    lv = 1'b1; ld = 8'hA5; se = 1'b1;
    #1;
    tests++;
    if (lr !== 1'b1) begin failed++; $display("FAIL a5_ready: load_ready=%b expected 1", lr); end
    push_word(8'hA5, 1'b1, 1'b0);
    tick();
    lv = 1'b0; ld = 8'h3C;
    for (int i = 0; i < FL; i++) begin
      #1;
      tests++;
      if (sv !== 1'b1 || sl !== (i == FL - 1)) begin
        failed++;
        $display("FAIL a5_frame: cycle %0d valid=%b last=%b expected 1 %b", i, sv, sl, (i == FL - 1));
      end
      tick();
    end
    #1;
    tests++;
    if ({sv, bz, lr} !== 3'b001) begin
      failed++;
      $display("FAIL a5_idle: valid/busy/ready=%b expected 001", {sv, bz, lr});
    end
  endtask

  task automatic test_lsb_01();
    lv2 = 1'b1; ld2 = 8'h01; se2 = 1'b1;
    push_word(8'h01, 1'b0, 1'b1);
    tick();
    lv2 = 1'b0; ld2 = 8'hFF;
    #1;
    tests++;
    if (sv2 !== 1'b1 || sb2 !== 1'b1) begin
      failed++;
      $display("FAIL lsb_first_bit: valid=%b bit=%b expected 1 1", sv2, sb2);
    end
    for (int i = 0; i < FL; i++) tick();
    #1;
    tests++;
    if (sv2 !== 1'b0 || q_l.size() != 0) begin
      failed++;
      $display("FAIL lsb_done: valid=%b pending=%0d expected 0 0", sv2, q_l.size());
    end
  endtask

  task automatic test_back_to_back();
    lv = 1'b1; ld = 8'hFF; se = 1'b1;
    push_word(8'hFF, 1'b1, 1'b0);
    tick();
    ld = 8'h00;
    for (int i = 0; i < 2 * FL; i++) begin
      #1;
      tests++;
      if (sv !== 1'b1 || sl !== (i == FL - 1 || i == 2 * FL - 1) || lr !== (i == FL - 1 || i == 2 * FL - 1)) begin
        failed++;
        $display("FAIL b2b_cycle: cycle %0d valid=%b last=%b ready=%b", i, sv, sl, lr);
      end
      if (i == FL - 1) push_word(8'h00, 1'b1, 1'b0);
      tick();
      if (i == FL - 1) lv = 1'b0;
    end
    #1;
    tests++;
    if (sv !== 1'b0 || q_m.size() != 0) begin
      failed++;
      $display("FAIL b2b_done: valid=%b pending=%0d expected 0 0", sv, q_m.size());
    end
  endtask

  task automatic test_stall();
    lv = 1'b1; ld = 8'hA5; se = 1'b1;
    push_word(8'hA5, 1'b1, 1'b0);
    tick();
    lv = 1'b0; ld = 8'h5A;
    for (int k = 0; k < FL + 3; k++) begin
      se = !(k >= 3 && k <= 5);
      #1;
      tests++;
      if (sv !== 1'b1 || sl !== (k == FL + 2)) begin
        failed++;
        $display("FAIL stall_frame: cycle %0d valid=%b last=%b", k, sv, sl);
      end
      if (k >= 3 && k <= 6) begin
        tests++;
        if (sb !== 1'b0) begin failed++; $display("FAIL stall_hold: cycle %0d bit=%b expected 0", k, sb); end
      end
      tick();
    end
    se = 1'b1;
    #1;
    tests++;
    if (sv !== 1'b0) begin failed++; $display("FAIL stall_done: valid=%b expected 0", sv); end
  endtask

  task automatic test_reset_midframe();
    lv = 1'b1; ld = 8'hC3; se = 1'b1;
    push_word(8'hC3, 1'b1, 1'b0);
    tick();
    lv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({sv, sb, sl, bz} !== 4'b0000) begin
      failed++;
      $display("FAIL midrst_outputs: valid/bit/last/busy=%b expected 0000", {sv, sb, sl, bz});
    end
    q_m.delete();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (lr !== 1'b1 || sv !== 1'b0) begin
      failed++;
      $display("FAIL midrst_release: ready=%b valid=%b expected 1 0", lr, sv);
    end
    lv = 1'b1; ld = 8'h81;
    push_word(8'h81, 1'b1, 1'b0);
    tick();
    lv = 1'b0;
    #1;
    tests++;
    if (sv !== 1'b1 || sb !== 1'b1) begin
      failed++;
      $display("FAIL midrst_restart: valid=%b bit=%b expected 1 1", sv, sb);
    end
    for (int i = 0; i < FL; i++) tick();
    #1;
    tests++;
    if (sv !== 1'b0 || q_m.size() != 0) begin
      failed++;
      $display("FAIL midrst_done: valid=%b pending=%0d expected 0 0", sv, q_m.size());
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       pexp  [2];
    words[0] = 8'h07; pexp[0] = 1'b1;
    words[1] = 8'h03; pexp[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      lv = 1'b1; ld = words[w]; se = 1'b1;
      push_word(words[w], 1'b1, 1'b0);
      tick();
      lv = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      #1;
      tests++;
      if (sb !== pexp[w] || sl !== 1'b1) begin
        failed++;
        $display("FAIL parity_bit: word %h bit=%b last=%b expected %b 1", words[w], sb, sl, pexp[w]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    tick();
    tests++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: pending msb=%0d lsb=%0d expected 0 0", q_m.size(), q_l.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out MSB first, 0 = LSB first.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 load_valid  input  1  parallel word offered.
REQ-006 load_ready  output  1  serializer accepts word this cycle.
REQ-007 load_data  input  WIDTH  parallel word; sampled only on handshake.
REQ-008 ser_en  input  1  downstream detector consumes current bit this cycle.
REQ-009 ser_bit  output  1  current serial bit, drives detector inp.
REQ-010 ser_valid  output  1  ser_bit is meaningful.
REQ-011 ser_last  output  1  ser_bit is final bit of frame.
REQ-012 busy  output  1  state is SHIFT.

Function
REQ-013 Two states, IDLE and SHIFT; handshake = load_valid && load_ready.
REQ-014 IDLE: load_ready=1, ser_valid=0, ser_bit=0, ser_last=0; handshake -> SHIFT, word captured, bit count cleared.
REQ-015 SHIFT: ser_valid=1; ser_bit = current bit per MSB_FIRST; first bit presented the cycle after handshake.
REQ-016 SHIFT with ser_en=1: advance one bit, count += 1; ser_en=0: ser_bit, count, ser_last held.
REQ-017 ser_last=1 exactly while final frame bit is presented; frame length FRAME_LEN = WIDTH (or WIDTH+1, see REQ-024).
REQ-018 load_ready = IDLE or (SHIFT and ser_last and ser_en); combinational from ser_en.
REQ-019 Final bit consumed with handshake: next word's first bit presented the next cycle, stay in SHIFT, no gap.
REQ-020 Final bit consumed without handshake: -> IDLE, ser_valid=0 next cycle.
REQ-021 load_data changes while not handshaking have no effect on the frame in flight.
REQ-022 Count width = clog2(FRAME_LEN+1); count never exceeds FRAME_LEN-1.

Reset
REQ-023 rst=1 immediately forces IDLE, clears shift register and count; outputs ser_valid=0, ser_bit=0, ser_last=0, busy=0, load_ready=1 (after release); a frame in flight is discarded, not resumed.

Configuration
REQ-024 Macro PISO_PARITY_EN defined: one even-parity bit (XOR of captured word) appended after the WIDTH data bits, FRAME_LEN=WIDTH+1, ser_last on parity bit.
REQ-025 PISO_PARITY_EN undefined: no parity bit, FRAME_LEN=WIDTH, no parity logic present.

Structure
REQ-026 Package piso_pkg holds the state typedef (IDLE, SHIFT) and the FRAME_LEN/count-width constant functions.
REQ-027 One sub-module piso_bit_counter: count register, clear, enable, terminal-count (last) output.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, load 8'hA5, ser_en=1 -> ser_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles after handshake, ser_last on 8th, then IDLE.
REQ-029 MSB_FIRST=0, load 8'h01, ser_en=1 -> ser_bit 1 then seven 0s; ser_last on 8th.
REQ-030 load_valid held, words 8'hFF then 8'h00 -> 16 contiguous ser_valid cycles, eight 1s then eight 0s, ser_last on cycles 8 and 16.
REQ-031 8'hA5, ser_en=0 for 3 cycles while 4th bit presented -> that bit (0) held 4 cycles, frame completes in 11 cycles.
REQ-032 rst pulsed while 5th bit presented -> ser_valid=0 same cycle, load_ready=1 after release, next word starts from its first bit.
REQ-033 PISO_PARITY_EN defined, 8'h07 -> 8 data bits then 9th bit 1 with ser_last; 8'h03 -> 9th bit 0.
